// File: rtl/elevator_pkg.sv
// elevator_pkg: floor, direction and lamp-index constants shared by the request front end.
package elevator_pkg;
  localparam logic [1:0] FLOOR1 = 2'd0;
  localparam logic [1:0] FLOOR2 = 2'd1;
  localparam logic [1:0] FLOOR3 = 2'd2;
  localparam logic [1:0] FLOOR4 = 2'd3;
  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;
  localparam int LAMP_CAR = 0;
  localparam int LAMP_HUP = 4;
  localparam int LAMP_HDN = 7;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: saturating run-length debouncer with a level and a one-cycle press pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam logic [3:0] DB = 4'(DB_CYCLES);
  logic [3:0] r_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else r_cnt <= !raw ? '0 : (level ? r_cnt : r_cnt + 4'd1);
  assign level = r_cnt == DB;
  // press lands on the edge that brings the counter to DB
  assign press = raw && r_cnt == DB - 4'd1;
endmodule

// File: rtl/call_request_register.sv
// call_request_register: debounces elevator buttons, latches calls and clears them when serviced.
module call_request_register
  import elevator_pkg::*;
#(
  parameter int DB_CYCLES = 3,
  parameter int NFLOORS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] btn_car,
  input  logic [NFLOORS-2:0] btn_hall_up,
  input  logic [NFLOORS-2:0] btn_hall_dn,
  input  logic               btn_dopen,
  input  logic [1:0]         floor,
  input  logic               up,
  input  logic               down,
  input  logic               door_open,
  output logic [NFLOORS-1:0] req_car,
  output logic [NFLOORS-2:0] req_hall_up,
  output logic [NFLOORS-2:0] req_hall_dn,
  output logic               req_dopen,
  output logic [9:0]         lamp,
  output logic               any_req
);
  logic [10:0] w_raw, w_press, w_level;
  logic        w_unused;
  logic [3:0]  r_car, w_sel, w_clr_car;
  logic [2:0]  r_up, r_dn, w_clr_up, w_clr_dn;
  logic        w_svc, w_up_at, w_dn_at;
  dir_t        r_dir;
  assign w_raw = {btn_dopen, btn_hall_dn, btn_hall_up, btn_car};
  for (genvar g = 0; g < 11; g++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk(clk), .reset(reset), .raw(w_raw[g]), .level(w_level[g]), .press(w_press[g])
    );
  end
  assign w_unused = ^{w_level[9:0], w_press[10]};
  // hall_dn bit i belongs to floor i+1, hence the shifted select
  always_comb begin
    w_sel     = 4'b0001 << floor;
    w_svc     = door_open && !up && !down;
    w_up_at   = |(r_up & w_sel[2:0]);
    w_dn_at   = |(r_dn & w_sel[3:1]);
    w_clr_car = w_svc ? w_sel : '0;
    w_clr_up  = (w_svc && (floor == FLOOR1 || r_dir == DIR_UP || !w_dn_at)) ? w_sel[2:0] : '0;
    w_clr_dn  = (w_svc && (floor == FLOOR4 || r_dir == DIR_DN || !w_up_at)) ? w_sel[3:1] : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_car <= '0;
      r_up  <= '0;
      r_dn  <= '0;
      r_dir <= DIR_UP;
    end else begin
      r_car <= (r_car | w_press[3:0]) & ~w_clr_car;
      r_up  <= (r_up | w_press[6:4]) & ~w_clr_up;
      r_dn  <= (r_dn | w_press[9:7]) & ~w_clr_dn;
      r_dir <= up ? DIR_UP : (down ? DIR_DN : r_dir);
    end
  a_dir: assert property (@(posedge clk) disable iff (!reset) !(up && down));
  assign req_car     = r_car;
  assign req_hall_up = r_up;
  assign req_hall_dn = r_dn;
  assign req_dopen   = w_level[10];
  assign lamp[LAMP_CAR +: 4] = r_car;
  assign lamp[LAMP_HUP +: 3] = r_up;
  assign lamp[LAMP_HDN +: 3] = r_dn;
  assign any_req = |{r_car, r_up, r_dn};
endmodule

// File: tb/tb_call_request_register.sv
// tb_call_request_register: scoreboard bench against a run-length/call-set reference model.
module tb_call_request_register;
  localparam int DB = 3;
  logic clk = 0, reset = 0;
  logic [3:0] btn_car = 0;
  logic [2:0] btn_hall_up = 0, btn_hall_dn = 0;
  logic btn_dopen = 0, up = 0, down = 0, door_open = 0;
  logic [1:0] floor = 0;
  logic [3:0] req_car;
  logic [2:0] req_hall_up, req_hall_dn;
  logic req_dopen, any_req;
  logic [9:0] lamp;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  call_request_register #(.DB_CYCLES(DB), .NFLOORS(4)) dut (
    .clk(clk), .reset(reset), .btn_car(btn_car), .btn_hall_up(btn_hall_up),
    .btn_hall_dn(btn_hall_dn), .btn_dopen(btn_dopen), .floor(floor), .up(up),
    .down(down), .door_open(door_open), .req_car(req_car), .req_hall_up(req_hall_up),
    .req_hall_dn(req_hall_dn), .req_dopen(req_dopen), .lamp(lamp), .any_req(any_req)
  );
  typedef struct packed {logic [3:0] car; logic [2:0] hu; logic [2:0] hd; logic dop;} exp_t;
  exp_t q[$];
  int run[11];
  logic [3:0] m_car = 0;
  logic [2:0] m_up = 0, m_dn = 0;
  logic m_dir = 0;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: calls are sets; a press happens when a button's high run length reaches DB
  always @(posedge clk) begin
    exp_t e;
    logic [10:0] raw, pr;
    logic [3:0] cc;
    logic [2:0] cu, cd;
    int f;
    raw = {btn_dopen, btn_hall_dn, btn_hall_up, btn_car};
    pr = 0; cc = 0; cu = 0; cd = 0;
    f = int'(floor);
    if (!reset) begin
      for (int i = 0; i < 11; i++) run[i] = 0;
      m_car = 0; m_up = 0; m_dn = 0; m_dir = 0;
    end else begin
      if (door_open && !up && !down) begin
        cc[f] = 1;
        if (f < 3 && (f == 0 || m_dir == 0 || !m_dn[f-1])) cu[f] = 1;
        if (f > 0 && (f == 3 || m_dir == 1 || !m_up[f])) cd[f-1] = 1;
      end
      for (int i = 0; i < 11; i++)
        if (!raw[i]) run[i] = 0;
        else if (run[i] < DB) begin
          run[i]++;
          pr[i] = run[i] == DB;
        end
      m_car = (m_car | pr[3:0]) & ~cc;
      m_up = (m_up | pr[6:4]) & ~cu;
      m_dn = (m_dn | pr[9:7]) & ~cd;
      if (up) m_dir = 0;
      else if (down) m_dir = 1;
    end
    e.car = m_car; e.hu = m_up; e.hd = m_dn; e.dop = run[10] == DB;
    q.push_back(e);
  end
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("req_car", 16'(req_car), 16'(e.car));
      chk("req_hall_up", 16'(req_hall_up), 16'(e.hu));
      chk("req_hall_dn", 16'(req_hall_dn), 16'(e.hd));
      chk("req_dopen", 16'(req_dopen), 16'(e.dop));
      chk("lamp", 16'(lamp), 16'({e.hd, e.hu, e.car}));
      chk("any_req", 16'(any_req), 16'(|{e.hd, e.hu, e.car}));
    end
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_outs"}, 16'({req_car, req_hall_up, req_hall_dn, req_dopen, any_req}), 16'd0);
    chk({name, "_lamp"}, 16'(lamp), 16'd0);
  endtask
  initial begin
    logic [10:0] rb;
    int mv;
    btn_car = 4'b0100;
    tick(3);
    chk_zero("reset_hold");
    reset = 1;
    tick(2);
    chk("car2_early", 16'(req_car), 16'd0);
    tick(1);
    chk("car2_latched", 16'(req_car), 16'b0100);
    btn_car = 0;
    btn_hall_up = 3'b010;
    tick(2);
    btn_hall_up = 0;
    tick(3);
    btn_car = 4'b1000;
    tick(4);
    btn_car = 0;
    floor = 3; door_open = 1;
    tick(1);
    door_open = 0;
    tick(1);
    btn_hall_up = 3'b010; btn_hall_dn = 3'b001;
    tick(4);
    btn_hall_up = 0; btn_hall_dn = 0;
    down = 1;
    tick(1);
    down = 0; floor = 1; door_open = 1;
    tick(1);
    door_open = 0;
    tick(1);
    floor = 0; door_open = 1; btn_car = 4'b0001;
    tick(4);
    btn_car = 0;
    door_open = 0;
    tick(1);
    btn_car = 4'b0001;
    tick(4);
    btn_car = 0;
    btn_dopen = 1;
    tick(5);
    btn_dopen = 0;
    tick(3);
    btn_hall_dn = 3'b100;
    tick(4);
    btn_car = 4'b0010;
    tick(1);
    reset = 0;
    #1;
    chk_zero("async_reset");
    tick(2);
    reset = 1;
    tick(6);
    btn_car = 0; btn_hall_dn = 0;
    for (int c = 0; c < 3000; c++) begin
      rb = {btn_dopen, btn_hall_dn, btn_hall_up, btn_car};
      for (int i = 0; i < 11; i++) if ($urandom_range(0, 3) == 0) rb[i] = ~rb[i];
      {btn_dopen, btn_hall_dn, btn_hall_up, btn_car} = rb;
      if ($urandom_range(0, 7) == 0) floor = 2'($urandom_range(0, 3));
      mv = $urandom_range(0, 5);
      up = mv == 0;
      down = mv == 1;
      door_open = mv > 1 && $urandom_range(0, 2) == 0;
      reset = $urandom_range(0, 499) != 0;
      if (!reset) begin
        #1;
        chk_zero("rand_reset");
      end
      tick(1);
    end
    reset = 1; up = 0; down = 0; door_open = 0;
    tick(2);
    chk("queue_drained", 16'(q.size() > 1), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
